// File: rtl/spi_bus_arbiter_pkg.sv
// Shared definitions for the SPI bus arbiter: FSM states and byte width.
// Imported by the arbiter top and anything that inspects its state.
package spi_bus_arbiter_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_BUSY,
    ST_HOLD,
    ST_GAP
  } arb_state_t;

endpackage

// File: rtl/spi_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr.
// Ports: req (requests), ptr (search start), gnt (one-hot), idx, any.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin sharing of one SPI byte engine among NUM_REQ requesters.
// Ports: req_* (tx bytes in), rsp_* (rx bytes out), grant, cs_n, spi_* (engine).
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [8*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [BYTE_W-1:0]     rsp_data,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    cs_n,
  input  logic                  spi_ready,
  output logic [BYTE_W-1:0]     spi_tx_data,
  output logic                  spi_data_valid,
  input  logic [BYTE_W-1:0]     spi_rx_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_SH = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_MAX = (MAX_SH > CS_GAP) ? MAX_SH : CS_GAP;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  arb_state_t state;

  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gidx;
  logic [PTR_W-1:0]   next_ptr;
  logic               is_last;
  logic               saw_low;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_any;
  logic [BYTE_W-1:0]  sel_data;
  logic               sel_valid;
  logic               sel_last;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Owner's byte lane, selected by the registered grant.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data  = req_data[8*i +: 8];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
    end
  end

  assign next_ptr = (gidx == PTR_W'(NUM_REQ - 1))
                  ? '0 : gidx + PTR_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      ptr            <= '0;
      gidx           <= '0;
      is_last        <= 1'b0;
      saw_low        <= 1'b0;
      grant          <= '0;
      cs_n           <= '1;
      req_ready      <= '0;
      rsp_valid      <= '0;
      rsp_data       <= '0;
      spi_tx_data    <= '0;
      spi_data_valid <= 1'b0;
    end else begin
      req_ready      <= '0;
      rsp_valid      <= '0;
      spi_data_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant <= arb_gnt;
            cs_n  <= ~arb_gnt;
            gidx  <= arb_idx;
            cnt   <= CNT_W'(CS_SETUP - 1);
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) state <= ST_ISSUE;
          else cnt <= cnt - CNT_W'(1);
        end
        ST_ISSUE: begin
          if (spi_ready && sel_valid) begin
            spi_data_valid <= 1'b1;
            spi_tx_data    <= sel_data;
            req_ready      <= grant;
            is_last        <= sel_last;
            saw_low        <= 1'b0;
            state          <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Byte is done only once ready has dropped and come back.
          if (!spi_ready) begin
            saw_low <= 1'b1;
          end else if (saw_low) begin
            rsp_data  <= spi_rx_data;
            rsp_valid <= grant;
            if (is_last) begin
              cnt   <= CNT_W'(CS_HOLD - 1);
              state <= ST_HOLD;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            cs_n  <= '1;
            grant <= '0;
            ptr   <= next_ptr;
            cnt   <= CNT_W'(CS_GAP - 1);
            state <= ST_GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt == '0) state <= ST_IDLE;
          else cnt <= cnt - CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Randomized bench for spi_bus_arbiter with an echoing SPI engine model.
// Reference: per-requester byte queues, round-robin pick, cs timing counts.
module tb_spi_bus_arbiter;

  localparam int N     = 2;
  localparam int SETUP = 4;
  localparam int HOLD  = 4;
  localparam int GAP   = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [7:0]     rsp_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   cs_n;
  logic           spi_ready;
  logic [7:0]     spi_tx_data;
  logic           spi_data_valid;
  logic [7:0]     spi_rx_data;

  spi_bus_arbiter #(
    .NUM_REQ  (N),
    .CS_SETUP (SETUP),
    .CS_HOLD  (HOLD),
    .CS_GAP   (GAP)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .grant          (grant),
    .cs_n           (cs_n),
    .spi_ready      (spi_ready),
    .spi_tx_data    (spi_tx_data),
    .spi_data_valid (spi_data_valid),
    .spi_rx_data    (spi_rx_data)
  );

  // Engine: takes a byte when idle, echoes its complement later.
  logic [7:0] eng_tx;
  int         eng_cnt;

  always @(posedge clock) begin
    if (reset) begin
      spi_ready   <= 1'b1;
      spi_rx_data <= 8'h00;
      eng_tx      <= 8'h00;
      eng_cnt     <= 0;
    end else if (!spi_ready) begin
      if (eng_cnt == 0) begin
        spi_ready   <= 1'b1;
        spi_rx_data <= eng_tx ^ 8'hFF;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end else if (spi_data_valid) begin
      spi_ready <= 1'b0;
      eng_tx    <= spi_tx_data;
      eng_cnt   <= int'($urandom_range(1, 6));
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       last;
  } tx_item_t;

  tx_item_t   txq[N][$];
  logic [7:0] expq[N][$];
  tx_item_t   acc_item[N];

  int n_cmp = 0;
  int n_err = 0;

  int ptr, owner, setup_cyc, hold_cnt, gap_cnt;
  bit got_byte, inflight_last, rnd_drop;
  logic [N-1:0] prev_grant, vld_at_edge, stall;
  int owner_log[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v,
                                 input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic push_txn(input int i, input int len,
                          input int base);
    logic [7:0] d;
    for (int b = 0; b < len; b++) begin
      d = (base < 0) ? 8'($urandom) : 8'(base + b);
      txq[i].push_back('{d, (b == len - 1)});
      expq[i].push_back(d ^ 8'hFF);
    end
  endtask

  task automatic drive();
    tx_item_t t;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && txq[i].size() > 0) begin
        t = txq[i].pop_front();
        acc_item[i] = t;
      end
      if (txq[i].size() > 0) begin
        req_valid[i] = !stall[i] &&
          !(rnd_drop && $urandom_range(0, 5) == 0);
        req_data[8*i +: 8] = txq[i][0].data;
        req_last[i] = txq[i][0].last;
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    logic [N-1:0] ng;
    int e, a;
    logic [7:0] x;
    ng = ~grant;
    chk("gnt_onehot0", 32'($onehot0(grant)), 1);
    chk("cs_vs_gnt", 32'(cs_n), 32'(ng));
    if (prev_grant == '0 && grant != '0) begin
      e = rr_pick(vld_at_edge, ptr);
      chk("rr_owner", 32'(grant),
          (e < 0) ? 32'd0 : (32'd1 << e));
      a = -1;
      for (int i = 0; i < N; i++) if (grant[i]) a = i;
      owner = a;
      owner_log.push_back(a);
      if (gap_cnt >= 0) chk("cs_gap", 32'(gap_cnt >= GAP), 1);
      gap_cnt = -1;
      setup_cyc = 0;
      got_byte = 0;
      hold_cnt = -1;
    end
    if (prev_grant != '0 && grant == '0) begin
      chk("cs_hold", 32'(hold_cnt), HOLD);
      if (owner >= 0) ptr = (owner + 1) % N;
      owner = -1;
      gap_cnt = 0;
    end
    if (grant == '0 && gap_cnt >= 0) gap_cnt++;
    chk("rdy_owned", 32'(req_ready & ng), 0);
    chk("dv_vs_rdy", 32'(spi_data_valid), 32'(|req_ready));
    chk("rdy_rsp_apart",
        32'(req_ready != '0 && rsp_valid != '0), 0);
    if (req_ready != '0 && owner >= 0) begin
      if (!got_byte)
        chk("cs_setup", 32'(setup_cyc >= SETUP + 1), 1);
      got_byte = 1;
      chk("tx_byte", 32'(spi_tx_data),
          32'(acc_item[owner].data));
      inflight_last = acc_item[owner].last;
    end else if (grant != '0 && !got_byte) begin
      setup_cyc++;
    end
    chk("rsp_owned", 32'(rsp_valid & ng), 0);
    if (rsp_valid != '0 && owner >= 0) begin
      if (expq[owner].size() == 0) begin
        chk("rsp_extra", 1, 0);
      end else begin
        x = expq[owner].pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(x));
      end
      if (inflight_last) hold_cnt = 0;
    end
    if (hold_cnt >= 0 && grant != '0) hold_cnt++;
    prev_grant = grant;
  endtask

  task automatic step(input bit mon);
    @(posedge clock);
    vld_at_edge = req_valid;
    #1;
    drive();
    @(negedge clock);
    if (mon) monitor();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      txq[i].delete();
      expq[i].delete();
    end
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    stall = '0;
    step(0);
    chk("rst_cs_n", 32'(cs_n), 32'((1 << N) - 1));
    chk("rst_grant", 32'(grant), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_spi_dv", 32'(spi_data_valid), 0);
    chk("rst_spi_tx", 32'(spi_tx_data), 0);
    reset = 1'b0;
    ptr = 0;
    owner = -1;
    prev_grant = '0;
    gap_cnt = -1;
    hold_cnt = -1;
    got_byte = 0;
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++)
      if (txq[i].size() > 0 || expq[i].size() > 0) return 1;
    return 0;
  endfunction

  task automatic run_idle(input int budget);
    int k;
    k = 0;
    while ((pending() || grant != '0) && k < budget) begin
      step(1);
      k++;
    end
    chk("idle_in_budget", 32'(k < budget), 1);
  endtask

  initial begin
    int k, m;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    stall = '0;
    rnd_drop = 0;
    vld_at_edge = '0;
    do_reset();

    // Single requester, bytes 01 02 03.
    push_txn(0, 3, 1);
    run_idle(400);
    chk("t1_owner", 32'(owner_log.size() > 0 ?
        owner_log[0] : -1), 0);

    // Both request right after reset: req0 first.
    do_reset();
    owner_log.delete();
    push_txn(0, 2, -1);
    push_txn(1, 2, -1);
    run_idle(600);
    chk("t2_count", 32'(owner_log.size()), 2);
    if (owner_log.size() == 2) begin
      chk("t2_first", 32'(owner_log[0]), 0);
      chk("t2_second", 32'(owner_log[1]), 1);
    end

    // req0 back-to-back with req1 pending: req1 wins round 2.
    owner_log.delete();
    push_txn(0, 2, -1);
    push_txn(0, 2, -1);
    push_txn(1, 1, -1);
    run_idle(900);
    chk("t3_count", 32'(owner_log.size()), 3);
    if (owner_log.size() == 3) begin
      chk("t3_r0", 32'(owner_log[0]), 0);
      chk("t3_r1", 32'(owner_log[1]), 1);
      chk("t3_r2", 32'(owner_log[2]), 0);
    end

    // Owner stalls 50 clocks mid-burst.
    push_txn(0, 3, -1);
    k = 0;
    while (!req_ready[0] && k < 200) begin
      step(1);
      k++;
    end
    chk("t4_first_byte", 32'(k < 200), 1);
    stall[0] = 1'b1;
    repeat (50) begin
      step(1);
      chk("stall_cs", 32'(cs_n[0]), 0);
      chk("stall_dv", 32'(spi_data_valid), 0);
    end
    stall[0] = 1'b0;
    run_idle(400);

    // Randomized traffic with sporadic valid drops.
    rnd_drop = 1;
    repeat (30) begin
      m = int'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        if (m[i]) push_txn(i, int'($urandom_range(1, 4)), -1);
      run_idle(3000);
    end
    rnd_drop = 0;

    // Reset while a byte is in flight.
    push_txn(1, 3, -1);
    k = 0;
    while (!(grant != '0 && !spi_ready) && k < 200) begin
      step(1);
      k++;
    end
    chk("t6_reached_busy", 32'(k < 200), 1);
    do_reset();
    repeat (4) step(1);
    chk("t6_idle_grant", 32'(grant), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
